// File: rtl/layer3_membrane_update_ctrl_if.sv
// Spike-input, membrane/weight memory and fire-output signals of the layer-3 membrane update controller.
interface layer3_membrane_update_ctrl_if #(
    parameter int IDX_WIDTH              = 8,
    parameter int NEURON_WIDTH           = 4,
    parameter int BIT_WIDTH_MEMBRANE     = 16,
    parameter int BIT_WIDTH_BIG_MEMBRANE = 16
);
    logic                                spike_valid_i;
    logic [IDX_WIDTH-1:0]                spike_idx_i;
    logic                                spike_ready_o;
    logic                                timestep_end_i;
    logic                                weight_rd_en_o;
    logic [IDX_WIDTH+NEURON_WIDTH-1:0]   weight_addr_o;
    logic                                mem_rd_en_o;
    logic [NEURON_WIDTH-1:0]             mem_rd_addr_o;
    logic [BIT_WIDTH_MEMBRANE-1:0]       mem_rd_data_i;
    logic                                mem_wr_en_o;
    logic [NEURON_WIDTH-1:0]             mem_wr_addr_o;
    logic [BIT_WIDTH_BIG_MEMBRANE-1:0]   mem_wr_data_o;
    logic                                weight_update_mode_o;
    logic                                small_membrane_update_mode_o;
    logic [BIT_WIDTH_BIG_MEMBRANE-1:0]   membrane_update_i;
    logic                                out_spike_o;
    logic [NEURON_WIDTH-1:0]             out_spike_neuron_o;
    logic                                busy_o;
    logic                                done_o;

    modport master (
        output spike_valid_i, spike_idx_i, timestep_end_i, mem_rd_data_i, membrane_update_i,
        input  spike_ready_o, weight_rd_en_o, weight_addr_o, mem_rd_en_o, mem_rd_addr_o,
               mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o, weight_update_mode_o,
               small_membrane_update_mode_o, out_spike_o, out_spike_neuron_o, busy_o, done_o
    );

    modport slave (
        input  spike_valid_i, spike_idx_i, timestep_end_i, mem_rd_data_i, membrane_update_i,
        output spike_ready_o, weight_rd_en_o, weight_addr_o, mem_rd_en_o, mem_rd_addr_o,
               mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o, weight_update_mode_o,
               small_membrane_update_mode_o, out_spike_o, out_spike_neuron_o, busy_o, done_o
    );
endinterface

// File: rtl/layer3_membrane_update_ctrl.sv
// Layer-3 membrane update sequencer: per-spike accumulate sweeps, then a threshold fire pass.
// Optional macro SOFT_RESET_EN: fired neurons keep (membrane - THRESHOLD) instead of 0.
module layer3_membrane_update_ctrl #(
    parameter int NUM_NEURON             = 10,
    parameter int NEURON_WIDTH           = 4,
    parameter int IDX_WIDTH              = 8,
    parameter int BIT_WIDTH_MEMBRANE     = 16,
    parameter int BIT_WIDTH_BIG_MEMBRANE = 16,
    parameter logic signed [BIT_WIDTH_MEMBRANE-1:0] THRESHOLD = 16'sd256
) (
    input logic                          clk_i,
    input logic                          reset_n_i,
    layer3_membrane_update_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ACCUM      = 3'd1,
        ST_ACC_DRAIN  = 3'd2,
        ST_FIRE       = 3'd3,
        ST_FIRE_DRAIN = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

    localparam logic [NEURON_WIDTH-1:0] LAST_N = NEURON_WIDTH'(NUM_NEURON - 1);
    localparam logic [NEURON_WIDTH-1:0] N_ONE  = NEURON_WIDTH'(1);

    state_t                            state_r, state_nx;
    logic [NEURON_WIDTH-1:0]           n_r, n_nx;
    logic [IDX_WIDTH-1:0]              idx_r, idx_nx;
    logic                              end_latch_r, end_latch_nx;
    logic                              ready_r, busy_r, done_r, small_mode_r;
    logic                              w_rd_en_r, m_rd_en_r;
    logic [NEURON_WIDTH-1:0]           rd_addr_r;
    logic [IDX_WIDTH+NEURON_WIDTH-1:0] weight_addr_r;
    logic                              acc_wr_r, fire_cmp_r;
    logic [NEURON_WIDTH-1:0]           wr_addr_r;
    logic                              accept_s, w_rd_nx_s, m_rd_nx_s;
    logic signed [BIT_WIDTH_MEMBRANE-1:0] mem_signed_s;
    logic                              fire_hit_s;
    logic [BIT_WIDTH_BIG_MEMBRANE-1:0] fire_data_s;

    // A spike is taken only when the registered ready is already visible to the producer.
    assign accept_s = bus.spike_valid_i & ready_r;

    // Next-state, neuron counter, captured spike index and timestep-end latch.
    always_comb begin
        state_nx = state_r;
        n_nx     = n_r;
        idx_nx   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx = ST_ACCUM;
                    n_nx     = '0;
                    idx_nx   = bus.spike_idx_i;
                end else if (end_latch_r || bus.timestep_end_i) begin
                    state_nx = ST_FIRE;
                    n_nx     = '0;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (n_r == LAST_N) begin
                    state_nx = ST_ACC_DRAIN;
                end else begin
                    n_nx = n_r + N_ONE;
                end
            end
            ST_ACC_DRAIN: begin
                if (accept_s) begin
                    state_nx = ST_ACCUM;
                    n_nx     = '0;
                    idx_nx   = bus.spike_idx_i;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_FIRE: begin
                if (n_r == LAST_N) begin
                    state_nx = ST_FIRE_DRAIN;
                end else begin
                    n_nx = n_r + N_ONE;
                end
            end
            ST_FIRE_DRAIN: state_nx = ST_DONE;
            ST_DONE:       state_nx = ST_IDLE;
            default:       state_nx = ST_IDLE;
        endcase

        // Clearing on FIRE entry wins so the end pulse that started the pass cannot re-arm it.
        if ((state_nx == ST_FIRE) && (state_r != ST_FIRE)) begin
            end_latch_nx = 1'b0;
        end else if (bus.timestep_end_i) begin
            end_latch_nx = 1'b1;
        end else begin
            end_latch_nx = end_latch_r;
        end
    end

    assign w_rd_nx_s = (state_nx == ST_ACCUM);
    assign m_rd_nx_s = (state_nx == ST_ACCUM) || (state_nx == ST_FIRE);

    // State and registered strobes: reads follow the next state, writes trail the current read by one cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r       <= ST_IDLE;
            n_r           <= '0;
            idx_r         <= '0;
            end_latch_r   <= 1'b0;
            ready_r       <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            small_mode_r  <= 1'b0;
            w_rd_en_r     <= 1'b0;
            m_rd_en_r     <= 1'b0;
            rd_addr_r     <= '0;
            weight_addr_r <= '0;
            acc_wr_r      <= 1'b0;
            fire_cmp_r    <= 1'b0;
            wr_addr_r     <= '0;
        end else begin
            state_r       <= state_nx;
            n_r           <= n_nx;
            idx_r         <= idx_nx;
            end_latch_r   <= end_latch_nx;
            ready_r       <= ((state_nx == ST_IDLE) || (state_nx == ST_ACC_DRAIN)) && !end_latch_nx;
            busy_r        <= (state_nx != ST_IDLE);
            done_r        <= (state_nx == ST_DONE);
            small_mode_r  <= (state_nx == ST_ACCUM) || (state_nx == ST_ACC_DRAIN);
            w_rd_en_r     <= w_rd_nx_s;
            m_rd_en_r     <= m_rd_nx_s;
            rd_addr_r     <= m_rd_nx_s ? n_nx : '0;
            weight_addr_r <= w_rd_nx_s ? {idx_nx, n_nx} : '0;
            acc_wr_r      <= (state_r == ST_ACCUM);
            fire_cmp_r    <= (state_r == ST_FIRE);
            wr_addr_r     <= ((state_r == ST_ACCUM) || (state_r == ST_FIRE)) ? n_r : '0;
        end
    end

    assign mem_signed_s = signed'(bus.mem_rd_data_i);
    assign fire_hit_s   = fire_cmp_r && (mem_signed_s >= THRESHOLD);

`ifdef SOFT_RESET_EN
    assign fire_data_s = BIT_WIDTH_BIG_MEMBRANE'(mem_signed_s) - BIT_WIDTH_BIG_MEMBRANE'(THRESHOLD);
`else
    assign fire_data_s = '0;
`endif

    // Write data follows the memory read by one cycle, so it is steered rather than registered.
    assign bus.mem_wr_en_o   = acc_wr_r | fire_hit_s;
    assign bus.mem_wr_addr_o = wr_addr_r;
    assign bus.mem_wr_data_o = acc_wr_r ? bus.membrane_update_i :
                               (fire_hit_s ? fire_data_s : '0);

    assign bus.out_spike_o                  = fire_hit_s;
    assign bus.out_spike_neuron_o           = fire_hit_s ? wr_addr_r : '0;
    assign bus.spike_ready_o                = ready_r;
    assign bus.weight_rd_en_o               = w_rd_en_r;
    assign bus.weight_addr_o                = weight_addr_r;
    assign bus.mem_rd_en_o                  = m_rd_en_r;
    assign bus.mem_rd_addr_o                = rd_addr_r;
    assign bus.weight_update_mode_o         = 1'b0;
    assign bus.small_membrane_update_mode_o = small_mode_r;
    assign bus.busy_o                       = busy_r;
    assign bus.done_o                       = done_r;
endmodule
